hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Producer-side companion to the EX-stage forwarding logic in the 5-stage RISC-V pipeline.
- Sits at ID and tracks destination registers of long-latency results (loads, multi-cycle mul/div) that the MEM/WB forwarding paths cannot yet supply.
- Stalls ID while any source or destination of the decoding instruction is still pending.
- Clears entries when the producing unit reports completion, handles EX flushes, and counts stall cycles.

Parameters:
- NREG, 32, number of architectural registers; x0 is never tracked.
- CNT_W, 32, stall-cycle counter width.

Ports:
- clk  input  1  rising-edge clock
- resetn  input  1  asynchronous active-low reset
- ID_Valid  input  1  valid instruction in ID
- ID_Rs1  input  5  source register 1
- ID_Rs2  input  5  source register 2
- ID_UsesRs1  input  1  instruction reads Rs1
- ID_UsesRs2  input  1  instruction reads Rs2
- ID_Rd  input  5  destination register
- ID_RegWrite  input  1  instruction writes Rd
- ID_LongOp  input  1  result is long-latency (load or mul/div)
- LongDone  input  1  a long-latency result has reached the WB-stage register this cycle
- LongDoneRd  input  5  destination of that result
- EX_Flush  input  1  squash the ID and EX instructions (branch taken or jump)
- Stall  output  1  combinational; hold PC and IF/ID, insert bubble into ID/EX
- Issue  output  1  combinational; instruction leaves ID this cycle
- Pending  output  NREG  registered pending bit vector
- StallCount  output  CNT_W  registered saturating count of Stall cycles

Behaviour:
- Reset (resetn low, asynchronous): Pending = 0, StallCount = 0, last-set record invalid. Stall and Issue therefore evaluate to 0 while ID_Valid is 0.
- Effective pending for a register r: eff(r) = Pending[r] & ~(LongDone & LongDoneRd == r). Completion is bypassed because the WB forwarding path covers the consumer next cycle. eff(0) is always 0.
- Stall = ID_Valid & ~EX_Flush & (RAW | WAW), where:
  - RAW = (ID_UsesRs1 & eff(ID_Rs1)) | (ID_UsesRs2 & eff(ID_Rs2))
  - WAW = ID_RegWrite & eff(ID_Rd)
- Issue = ID_Valid & ~Stall & ~EX_Flush.
- Set rule: on a clock edge with Issue & ID_RegWrite & ID_LongOp & ID_Rd != 0:
  - Pending[ID_Rd] <= 1.
  - Record {valid=1, rd=ID_Rd} as last-set.
  - On any other edge, the last-set record becomes invalid.
- Clear rule: on an edge with LongDone & LongDoneRd != 0, Pending[LongDoneRd] <= 0.
- Flush rule: on an edge with EX_Flush and a valid last-set record, Pending[last-set rd] <= 0, because the long op now in EX is squashed. ID is also squashed, so no set occurs on that edge.
- Priority on the same register, same edge: set > clear, and set > flush-clear.
- LongDone for a register that is not pending is a no-op.
- Multiple bits may be pending at once. WAW stalling guarantees at most one outstanding producer per register, so completions need no tags.
- StallCount increments on every edge where Stall = 1 and saturates at all-ones; it never wraps.
- Latency: Pending reflects set/clear one cycle after the triggering edge. Stall reacts in the same cycle to LongDone.
- resetn asserted mid-operation: all pending bits drop immediately. The pipeline is reset simultaneously, so no stale completions follow.

Test Plan:
1. Reset, then ID_Valid=1, Rs1=5, no pending -> Stall=0, Issue=1, Pending=0, StallCount=0.
2. Issue a load to x7 (LongOp=1), then next instruction uses Rs1=7 -> Pending[7]=1, Stall=1 for 3 cycles. Assert LongDone, LongDoneRd=7 in cycle 4 -> Stall=0 that cycle, Pending[7]=0 next cycle, StallCount=3.
3. Long op to x0 -> Pending stays 0. Later consumer of x0 -> Stall=0.
4. Long op to x9 issues, EX_Flush next cycle -> Pending[9] cleared. Subsequent read of x9 -> Stall=0.
5. Pending[4]=1; issue a long op to x4 while LongDone, LongDoneRd=4 in the same cycle -> Stall=0 (bypass), Issue=1, Pending[4] remains 1 (set wins).
6. Force Stall high for 2^CNT_W+5 cycles with a small CNT_W override (e.g. 4) -> StallCount holds at 15, no wrap. Assert resetn low mid-stall -> Pending and StallCount go to 0 asynchronously.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// ID-stage scoreboard for long-latency results (loads, mul/div).
// Stalls ID on RAW/WAW against pending destinations and counts stall cycles.
module hazard_scoreboard #(
  parameter int unsigned NREG  = 32,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             ID_Valid,
  input  logic [4:0]       ID_Rs1,
  input  logic [4:0]       ID_Rs2,
  input  logic             ID_UsesRs1,
  input  logic             ID_UsesRs2,
  input  logic [4:0]       ID_Rd,
  input  logic             ID_RegWrite,
  input  logic             ID_LongOp,
  input  logic             LongDone,
  input  logic [4:0]       LongDoneRd,
  input  logic             EX_Flush,
  output logic             Stall,
  output logic             Issue,
  output logic [NREG-1:0]  Pending,
  output logic [CNT_W-1:0] StallCount
);

  logic [NREG-1:0]  pending_q, pending_d;
  logic [NREG-1:0]  done_mask, eff;
  logic             last_valid_q, last_valid_d;
  logic [4:0]       last_rd_q, last_rd_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             raw, waw, set_en;

  // A completing result is forwarded from WB, so it no longer blocks a consumer.
  always_comb begin
    done_mask = '0;
    if (LongDone) done_mask[LongDoneRd] = 1'b1;
    eff    = pending_q & ~done_mask;
    eff[0] = 1'b0;
    raw    = (ID_UsesRs1 & eff[ID_Rs1]) | (ID_UsesRs2 & eff[ID_Rs2]);
    waw    = ID_RegWrite & eff[ID_Rd];
    Stall  = ID_Valid & ~EX_Flush & (raw | waw);
    Issue  = ID_Valid & ~Stall & ~EX_Flush;
    set_en = Issue & ID_RegWrite & ID_LongOp & (ID_Rd != 5'd0);
  end

  // Later assignments win: set overrides both completion and flush clears.
  always_comb begin
    pending_d = pending_q;
    if (LongDone && LongDoneRd != 5'd0) pending_d[LongDoneRd] = 1'b0;
    if (EX_Flush && last_valid_q) pending_d[last_rd_q] = 1'b0;
    if (set_en) pending_d[ID_Rd] = 1'b1;

    last_valid_d = set_en;
    last_rd_d    = set_en ? ID_Rd : last_rd_q;

    count_d = count_q;
    if (Stall && count_q != '1) count_d = count_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pending_q    <= '0;
      last_valid_q <= 1'b0;
      last_rd_q    <= 5'd0;
      count_q      <= '0;
    end else begin
      pending_q    <= pending_d;
      last_valid_q <= last_valid_d;
      last_rd_q    <= last_rd_d;
      count_q      <= count_d;
    end
  end

  assign Pending    = pending_q;
  assign StallCount = count_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed vector table, saturation and
// async-reset sequence, then randomized traffic against a register-array model.
module tb_hazard_scoreboard;

  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          resetn;
  logic          id_valid, id_uses1, id_uses2, id_regwrite, id_longop;
  logic [4:0]    id_rs1, id_rs2, id_rd, done_rd;
  logic          long_done, ex_flush;
  logic          stall, issue;
  logic [31:0]   pending;
  logic [CW-1:0] stall_count;

  int checks = 0;
  int passed = 0;

  hazard_scoreboard #(.NREG(32), .CNT_W(CW)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .ID_Valid   (id_valid),
    .ID_Rs1     (id_rs1),
    .ID_Rs2     (id_rs2),
    .ID_UsesRs1 (id_uses1),
    .ID_UsesRs2 (id_uses2),
    .ID_Rd      (id_rd),
    .ID_RegWrite(id_regwrite),
    .ID_LongOp  (id_longop),
    .LongDone   (long_done),
    .LongDoneRd (done_rd),
    .EX_Flush   (ex_flush),
    .Stall      (stall),
    .Issue      (issue),
    .Pending    (pending),
    .StallCount (stall_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          v;
    logic [4:0]    rs1;
    logic          u1;
    logic [4:0]    rs2;
    logic          u2;
    logic [4:0]    rd;
    logic          rw;
    logic          lo;
    logic          ld;
    logic [4:0]    ldrd;
    logic          fl;
    logic          e_stall;
    logic          e_issue;
    logic [31:0]   e_pend;
    logic [CW-1:0] e_cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic v, input logic [4:0] rs1, input logic u1,
                              input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                              input logic rw, input logic lo, input logic ld,
                              input logic [4:0] ldrd, input logic fl, input logic es,
                              input logic ei, input logic [31:0] ep, input logic [CW-1:0] ec);
    vec_t t;
    t.v = v; t.rs1 = rs1; t.u1 = u1; t.rs2 = rs2; t.u2 = u2; t.rd = rd; t.rw = rw;
    t.lo = lo; t.ld = ld; t.ldrd = ldrd; t.fl = fl; t.e_stall = es; t.e_issue = ei;
    t.e_pend = ep; t.e_cnt = ec;
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic drive(input logic v, input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                       input logic rw, input logic lo, input logic ld,
                       input logic [4:0] ldrd, input logic fl);
    id_valid = v; id_rs1 = rs1; id_uses1 = u1; id_rs2 = rs2; id_uses2 = u2;
    id_rd = rd; id_regwrite = rw; id_longop = lo; long_done = ld; done_rd = ldrd;
    ex_flush = fl;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  // Reference model: one bit per architectural register plus last-issued long rd.
  bit m_pend[32];
  int m_last;
  int m_cnt;
  localparam int CMAX = (1 << CW) - 1;

  function automatic bit m_eff(input int r);
    return (r != 0) && m_pend[r] && !(long_done && int'(done_rd) == r);
  endfunction

  function automatic logic [31:0] m_vec();
    logic [31:0] v = '0;
    for (int i = 0; i < 32; i++) v[i] = m_pend[i];
    return v;
  endfunction

  initial begin
    bit e_stall, e_issue, setting;
    resetn = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 resetn = 1'b0;
    #1;
    chk("async_reset_pending", pending, 0);
    chk("async_reset_count", stall_count, 0);
    do_reset();
    chk("reset_stall", stall, 0);
    chk("reset_issue", issue, 0);

    //        v rs1 u1 rs2 u2 rd rw lo ld ldrd fl  stall issue pend       cnt
    tbl.push_back(mk(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0, 0, 1, 32'h80, 0));
    tbl.push_back(mk(1, 7, 1, 0, 0, 8, 1, 0, 0, 0, 0, 1, 0, 32'h80, 1));
    tbl.push_back(mk(1, 7, 1, 0, 0, 8, 1, 0, 0, 0, 0, 1, 0, 32'h80, 2));
    tbl.push_back(mk(1, 7, 1, 0, 0, 8, 1, 0, 0, 0, 0, 1, 0, 32'h80, 3));
    tbl.push_back(mk(1, 7, 1, 0, 0, 8, 1, 0, 1, 7, 0, 0, 1, 32'h0, 3));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 32'h0, 3));
    tbl.push_back(mk(1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0, 3));
    tbl.push_back(mk(1, 0, 0, 0, 0, 9, 1, 1, 0, 0, 0, 0, 1, 32'h200, 3));
    tbl.push_back(mk(1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h0, 3));
    tbl.push_back(mk(1, 0, 0, 9, 1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0, 3));
    tbl.push_back(mk(1, 0, 0, 0, 0, 4, 1, 1, 0, 0, 0, 0, 1, 32'h10, 3));
    tbl.push_back(mk(1, 0, 0, 0, 0, 4, 1, 1, 1, 4, 0, 0, 1, 32'h10, 3));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 4, 0, 0, 0, 32'h0, 3));
    tbl.push_back(mk(1, 0, 0, 0, 0, 11, 1, 1, 0, 0, 0, 0, 1, 32'h800, 3));
    tbl.push_back(mk(1, 0, 0, 0, 0, 11, 1, 0, 0, 0, 0, 1, 0, 32'h800, 4));
    tbl.push_back(mk(1, 0, 0, 0, 0, 11, 1, 0, 1, 11, 0, 0, 1, 32'h0, 4));
    tbl.push_back(mk(1, 0, 0, 0, 0, 12, 1, 1, 0, 0, 0, 0, 1, 32'h1000, 4));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h1000, 4));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h1000, 4));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 12, 0, 0, 0, 32'h0, 4));

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].v, tbl[i].rs1, tbl[i].u1, tbl[i].rs2, tbl[i].u2, tbl[i].rd, tbl[i].rw,
            tbl[i].lo, tbl[i].ld, tbl[i].ldrd, tbl[i].fl);
      #2;
      chk($sformatf("vec%0d_stall", i), stall, tbl[i].e_stall);
      chk($sformatf("vec%0d_issue", i), issue, tbl[i].e_issue);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_pending", i), pending, tbl[i].e_pend);
      chk($sformatf("vec%0d_count", i), stall_count, tbl[i].e_cnt);
    end

    // Saturation: hold a RAW stall on x3 for 2^CW+5 cycles, then reset mid-cycle.
    do_reset();
    drive(1, 0, 0, 0, 0, 3, 1, 1, 0, 0, 0);
    @(negedge clk);
    drive(1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat ((1 << CW) + 5) @(posedge clk);
    #1;
    chk("sat_count", stall_count, CMAX);
    chk("sat_stall", stall, 1);
    chk("sat_pending", pending, 32'h8);
    #2 resetn = 1'b0;
    #1;
    chk("midreset_pending", pending, 0);
    chk("midreset_count", stall_count, 0);
    chk("midreset_stall", stall, 0);

    // Randomized traffic, reset every 64 cycles so the counter is exercised from 0.
    for (int cyc = 0; cyc < 640; cyc++) begin
      if (cyc % 64 == 0) begin
        do_reset();
        foreach (m_pend[r]) m_pend[r] = 0;
        m_last = -1;
        m_cnt  = 0;
      end
      @(negedge clk);
      drive($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 9) < 4,
            5'($urandom_range(0, 7)), $urandom_range(0, 9) == 0);
      e_stall = id_valid && !ex_flush &&
                ((id_uses1 && m_eff(id_rs1)) || (id_uses2 && m_eff(id_rs2)) ||
                 (id_regwrite && m_eff(id_rd)));
      e_issue = id_valid && !e_stall && !ex_flush;
      setting = e_issue && id_regwrite && id_longop && id_rd != 0;
      #2;
      chk("rand_stall", stall, e_stall);
      chk("rand_issue", issue, e_issue);
      if (long_done && done_rd != 0) m_pend[done_rd] = 0;
      if (ex_flush && m_last >= 0) m_pend[m_last] = 0;
      if (setting) m_pend[id_rd] = 1;
      m_last = setting ? int'(id_rd) : -1;
      if (e_stall && m_cnt < CMAX) m_cnt++;
      @(posedge clk);
      #1;
      chk("rand_pending", pending, m_vec());
      chk("rand_count", stall_count, m_cnt);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
